// File: rtl/i2s_tx_param_if.sv
// rtl/i2s_tx_param_if.sv - upstream stereo frame handshake bundle for i2s_tx_param
//
// Purpose: carries one stereo frame per transfer from the sample FIFO to the
// I2S transmitter. A transfer happens on an MCLK edge with S_VALID && S_READY.
// Signals:
//   S_VALID  master->slave  frame valid; held with data until accepted
//   S_READY  slave->master  transmitter holding register is empty
//   S_LEFT   master->slave  left sample, two's complement, DATA_W bits
//   S_RIGHT  master->slave  right sample, two's complement, DATA_W bits
interface i2s_tx_param_if #(
    parameter int DATA_W = 24
);
    logic              S_VALID;
    logic              S_READY;
    logic [DATA_W-1:0] S_LEFT;
    logic [DATA_W-1:0] S_RIGHT;

    modport master (output S_VALID, output S_LEFT, output S_RIGHT, input S_READY);
    modport slave  (input S_VALID, input S_LEFT, input S_RIGHT, output S_READY);
endinterface

// File: rtl/i2s_tx_param.sv
// rtl/i2s_tx_param.sv - parametrised stereo I2S / left-justified transmitter
//
// Purpose: serialises one stereo frame per LRCLK period onto SDATA, generating
// SCLK and LRCLK from MCLK. Frames come from a one-deep holding register fed by
// a valid/ready handshake; a frame slot that finds the holding register empty
// transmits zeros and pulses UNDERFLOW.
// Ports:
//   MCLK       in   master clock, all logic on posedge
//   RESET      in   synchronous, active-high
//   S          slave modport of i2s_tx_param_if (S_VALID/S_READY/S_LEFT/S_RIGHT)
//   SCLK       out  bit clock, MCLK/MCLK_PER_SCLK, 50% duty, registered
//   LRCLK      out  0 = left slot, 1 = right slot, registered
//   SDATA      out  serial data, changes on SCLK fall, registered
//   UNDERFLOW  out  one-MCLK pulse when a frame load finds holding empty
module i2s_tx_param #(
    parameter int DATA_W        = 24,
    parameter int SLOT_W        = 32,
    parameter int MCLK_PER_SCLK = 4,
    parameter int JUSTIFY       = 0
) (
    input  logic          MCLK,
    input  logic          RESET,
    i2s_tx_param_if.slave S,
    output logic          SCLK,
    output logic          LRCLK,
    output logic          SDATA,
    output logic          UNDERFLOW
);
    localparam int DIV_W = $clog2(MCLK_PER_SCLK);
    localparam int BIT_W = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_PER_SCLK - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCLK_PER_SCLK / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] SLOT_C   = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] DATA_C   = BIT_W'(DATA_W);
    // I2S delays the MSB by one SCLK, so its frame starts at bit_cnt = 1.
    localparam logic [BIT_W-1:0] LOAD_POS = (JUSTIFY == 0) ? BIT_W'(1) : '0;

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              sclk_q, sclk_d;
    logic              lrclk_q, lrclk_d;
    logic              sdata_q, sdata_d;
    logic              underflow_q, underflow_d;
    logic              s_ready_q, s_ready_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [DATA_W-1:0] act_l_q, act_l_d, act_r_q, act_r_d;

    logic              fall;
    logic              load;
    logic              accept;
    logic [BIT_W-1:0]  pos;
    logic [BIT_W-1:0]  k;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        act_l_d     = act_l_q;
        act_r_d     = act_r_q;
        hold_full_d = hold_full_q;
        underflow_d = 1'b0;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        bit_cnt_d   = bit_cnt_q;

        fall      = (div_cnt_q == DIV_LAST);
        div_cnt_d = fall ? '0 : div_cnt_q + 1'b1;
        if (fall) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        end
        sclk_d = (div_cnt_d >= DIV_HALF);

        // The load looks at hold_full_q before this edge's accept lands, so a
        // frame accepted on a load edge waits for the following load.
        load   = fall && (bit_cnt_d == LOAD_POS);
        accept = S.S_VALID && s_ready_q;
        if (load) begin
            if (hold_full_q) begin
                act_l_d     = hold_l_q;
                act_r_d     = hold_r_q;
                hold_full_d = 1'b0;
            end else begin
                act_l_d     = '0;
                act_r_d     = '0;
                underflow_d = 1'b1;
            end
        end
        if (accept) begin
            hold_l_d    = S.S_LEFT;
            hold_r_d    = S.S_RIGHT;
            hold_full_d = 1'b1;
        end
        s_ready_d = !hold_full_d;

        // Position within the frame relative to its MSB; uses the freshly
        // loaded active data so the MSB goes out on the load edge itself.
        if ((JUSTIFY == 0) && (bit_cnt_d == '0)) begin
            pos = BIT_LAST;
        end else begin
            pos = bit_cnt_d - LOAD_POS;
        end
        if (pos >= SLOT_C) begin
            word = act_r_d;
            k    = pos - SLOT_C;
        end else begin
            word = act_l_d;
            k    = pos;
        end
        shifted = word << k;
        if (fall) begin
            lrclk_d = (bit_cnt_d >= SLOT_C);
            sdata_d = (k < DATA_C) ? shifted[DATA_W-1] : 1'b0;
        end
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            sclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            underflow_q <= 1'b0;
            s_ready_q   <= 1'b0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            act_l_q     <= '0;
            act_r_q     <= '0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sclk_q      <= sclk_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            underflow_q <= underflow_d;
            s_ready_q   <= s_ready_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            act_l_q     <= act_l_d;
            act_r_q     <= act_r_d;
        end
    end

    assign SCLK      = sclk_q;
    assign LRCLK     = lrclk_q;
    assign SDATA     = sdata_q;
    assign UNDERFLOW = underflow_q;
    assign S.S_READY = s_ready_q;
endmodule

// File: tb/tb_i2s_tx_param.sv
// tb/tb_i2s_tx_param.sv - scoreboard bench for i2s_tx_param in three configurations
module tb_i2s_tx_param;
    localparam int NI = 3;
    localparam int TIMEOUT_CYCLES = 20000;

    function automatic int cfg_dw(input int i);
        return (i == 2) ? 16 : 24;
    endfunction
    function automatic int cfg_sw(input int i);
        return (i == 2) ? 16 : 32;
    endfunction
    function automatic int cfg_m(input int i);
        return (i == 2) ? 8 : 4;
    endfunction
    function automatic int cfg_j(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    logic        MCLK = 1'b0;
    logic        RESET = 1'b1;
    logic        s_valid_t [NI];
    logic [31:0] s_left_t  [NI];
    logic [31:0] s_right_t [NI];
    logic [4:0]  obs       [NI];

    int n = 0;
    int gcyc = 0;
    int checks = 0;
    int failures = 0;
    bit done = 1'b0;

    typedef struct {
        int          inst;
        int          tag;
        logic [31:0] l;
        logic [31:0] r;
    } frame_t;
    frame_t      sbq[$];
    logic [31:0] cur_l [NI];
    logic [31:0] cur_r [NI];
    bit          acc_prev [NI];
    int          ctr [NI];

    always #5 MCLK = ~MCLK;

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int DW = cfg_dw(gi);
        logic sclk, lrclk, sdata, uf;
        i2s_tx_param_if #(.DATA_W(DW)) bus ();
        assign bus.S_VALID = s_valid_t[gi];
        assign bus.S_LEFT  = s_left_t[gi][DW-1:0];
        assign bus.S_RIGHT = s_right_t[gi][DW-1:0];
        i2s_tx_param #(
            .DATA_W(DW),
            .SLOT_W(cfg_sw(gi)),
            .MCLK_PER_SCLK(cfg_m(gi)),
            .JUSTIFY(cfg_j(gi))
        ) dut (
            .MCLK(MCLK),
            .RESET(RESET),
            .S(bus),
            .SCLK(sclk),
            .LRCLK(lrclk),
            .SDATA(sdata),
            .UNDERFLOW(uf)
        );
        assign obs[gi] = {sclk, lrclk, sdata, uf, bus.S_READY};
    end

    always @(posedge MCLK) begin
        gcyc <= gcyc + 1;
        if (RESET) n <= 0;
        else       n <= n + 1;
    end

    always @(negedge MCLK) begin
        for (int i = 0; i < NI; i++) begin
            int m, h, s, dw, d, g, pos, k, idx;
            logic uf, rdy, sd;
            logic [31:0] w;
            logic [4:0]  expv;
            m  = cfg_m(i);
            h  = m / 2;
            s  = cfg_sw(i);
            dw = cfg_dw(i);
            d  = (cfg_j(i) == 0) ? 1 : 0;
            uf = 1'b0;
            if (n == 0) begin
                cur_l[i] = '0;
                cur_r[i] = '0;
                for (int j = sbq.size() - 1; j >= 0; j--)
                    if (sbq[j].inst == i) sbq.delete(j);
            end else if ((n % m == 0) && ((n / m) % (2 * s) == d)) begin
                idx = -1;
                for (int j = 0; j < sbq.size(); j++)
                    if (idx < 0 && sbq[j].inst == i && sbq[j].tag < gcyc) idx = j;
                if (idx >= 0) begin
                    cur_l[i] = sbq[idx].l;
                    cur_r[i] = sbq[idx].r;
                    sbq.delete(idx);
                end else begin
                    cur_l[i] = '0;
                    cur_r[i] = '0;
                    uf = 1'b1;
                end
            end
            rdy = (n != 0);
            for (int j = 0; j < sbq.size(); j++)
                if (sbq[j].inst == i && sbq[j].tag <= gcyc) rdy = 1'b0;
            g   = n / m;
            pos = (g + 2 * s - d) % (2 * s);
            k   = pos % s;
            w   = (pos >= s) ? cur_r[i] : cur_l[i];
            sd  = (k < dw) ? w[dw-1-k] : 1'b0;
            expv = {((n % m) >= h), ((g % (2 * s)) >= s), sd, uf, rdy};
            checks++;
            if (obs[i] !== expv) begin
                failures++;
                $display("FAIL inst%0d n=%0d {sclk,lrclk,sdata,underflow,ready} got=%b want=%b",
                         i, n, obs[i], expv);
            end
        end
    end

    initial begin
        repeat (TIMEOUT_CYCLES) @(posedge MCLK);
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL timeout: stimulus did not complete within %0d MCLK cycles", TIMEOUT_CYCLES);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic drive_cycle(input int mode);
        frame_t      f;
        logic [31:0] mask;
        @(negedge MCLK);
        for (int i = 0; i < NI; i++) begin
            mask = (32'd1 << cfg_dw(i)) - 32'd1;
            if (!s_valid_t[i] || acc_prev[i]) begin
                if (mode == 0)      s_valid_t[i] = ($urandom_range(0, 1) == 1);
                else if (mode == 1) s_valid_t[i] = 1'b0;
                else                s_valid_t[i] = 1'b1;
                if (mode == 2) begin
                    ctr[i]++;
                    s_left_t[i]  = (32'(ctr[i]) * 32'd2) & mask;
                    s_right_t[i] = (32'(ctr[i]) * 32'd2 + 32'd1) & mask;
                end else begin
                    s_left_t[i]  = $urandom & mask;
                    s_right_t[i] = $urandom & mask;
                end
            end
            acc_prev[i] = s_valid_t[i] && obs[i][0];
            if (acc_prev[i]) begin
                f.inst = i;
                f.tag  = gcyc + 1;
                f.l    = s_left_t[i];
                f.r    = s_right_t[i];
                sbq.push_back(f);
            end
        end
    endtask

    task automatic run_phase(input int mode, input int cycles);
        for (int c = 0; c < cycles; c++) drive_cycle(mode);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            s_valid_t[i] = 1'b0;
            s_left_t[i]  = '0;
            s_right_t[i] = '0;
            acc_prev[i]  = 1'b0;
            ctr[i]       = 0;
        end
        RESET = 1'b1;
        repeat (3) @(negedge MCLK);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs[i] !== 5'b00000) begin
                failures++;
                $display("FAIL reset state inst%0d {sclk,lrclk,sdata,underflow,ready} got=%b want=00000",
                         i, obs[i]);
            end
        end
        RESET = 1'b0;
        run_phase(0, 1500);
        run_phase(1, 700);
        run_phase(2, 1600);
        for (int c = 0; c < 256 && (n % 256) != 180; c++) drive_cycle(2);
        @(negedge MCLK);
        RESET = 1'b1;
        for (int i = 0; i < NI; i++) begin
            s_valid_t[i] = 1'b0;
            acc_prev[i]  = 1'b0;
        end
        @(negedge MCLK);
        RESET = 1'b0;
        run_phase(0, 1500);
        run_phase(2, 600);
        run_phase(1, 300);
        @(negedge MCLK);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
